// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and routing helper for the multicycle arithmetic ALU.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_DIV = 3'b011;
  localparam logic [2:0] ALU_MOD = 3'b100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } alu_state_e;

  // True when the opcode needs the iterative datapath; divide-by-zero completes immediately.
  function automatic logic is_iter_op(input logic [2:0] sel, input logic b_zero);
    return (sel == ALU_MUL) || (((sel == ALU_DIV) || (sel == ALU_MOD)) && !b_zero);
  endfunction

endpackage

// File: rtl/alu_multicycle_arith_if.sv
// Operand/result handshake bundle for alu_multicycle_arith.
interface alu_multicycle_arith_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         ALU_Sel;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] ALU_Out;
  logic               CarryOut;
  logic               Zero;
  logic               Error;

  modport master (
    output in_valid, A, B, ALU_Sel, out_ready,
    input  in_ready, out_valid, ALU_Out, CarryOut, Zero, Error
  );

  modport slave (
    input  in_valid, A, B, ALU_Sel, out_ready,
    output in_ready, out_valid, ALU_Out, CarryOut, Zero, Error
  );

endinterface

// File: rtl/alu_iter_unit.sv
// Shift-add multiplier and restoring divider, one bit per cycle while the counter is non-zero.
module alu_iter_unit #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_is_div,
  input  logic [CNT_W-1:0]   i_cnt,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_product,
  output logic [WIDTH-1:0]   o_quotient,
  output logic [WIDTH-1:0]   o_remainder
);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;

  logic               w_step;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;

  // When w_ge holds the true difference is below the divisor, so the WIDTH-bit wrap is exact.
  always_comb begin
    w_step  = (i_cnt != '0) && !i_start;
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_divisor});
    w_sub   = w_shift[WIDTH-1:0] - r_divisor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_prod    <= '0;
      r_divisor <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
    end else if (i_start) begin
      if (i_is_div) begin
        r_divisor <= i_b;
        r_quo     <= i_a;
        r_rem     <= '0;
      end else begin
        r_mcand  <= {{WIDTH{1'b0}}, i_a};
        r_mplier <= i_b;
        r_prod   <= '0;
      end
    end else if (w_step) begin
      if (i_is_div) begin
        r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
      end else begin
        if (r_mplier[0]) begin
          r_prod <= r_prod + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
    end
  end

  assign o_product   = r_prod;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/alu_multicycle_arith.sv
// Clocked unsigned ALU: single-cycle ADD/SUB, WIDTH-cycle MUL/DIV/MOD, valid/ready on both sides.
module alu_multicycle_arith
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  alu_multicycle_arith_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  alu_state_e         r_state;
  alu_state_e         w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_op;
  logic               r_iter;
  logic [2*WIDTH-1:0] r_out;
  logic               r_carry;
  logic               r_error;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_b_zero;
  logic               w_iter_op;
  logic               w_is_div;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_quick_out;
  logic               w_quick_carry;
  logic               w_quick_err;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_quotient;
  logic [WIDTH-1:0]   w_remainder;
  logic [2*WIDTH-1:0] w_result;
  logic               w_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: if (bus.in_valid) w_state_next = w_iter_op ? StBusy : StDone;
      StBusy: if (r_cnt == CNT_W'(1)) w_state_next = StDone;
      StDone: if (bus.out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == StIdle) && !rst;
    w_out_valid = (r_state == StDone);
  end

  assign w_accept  = w_in_ready && bus.in_valid;
  assign w_b_zero  = (bus.B == '0);
  assign w_iter_op = is_iter_op(bus.ALU_Sel, w_b_zero);
  // The unit sees the live opcode on the start cycle and the latched one while stepping.
  assign w_is_div  = w_accept ? (bus.ALU_Sel != ALU_MUL) : (r_op != ALU_MUL);

  always_comb begin
    w_sum         = {1'b0, bus.A} + {1'b0, bus.B};
    w_diff        = bus.A - bus.B;
    w_quick_out   = '0;
    w_quick_carry = 1'b0;
    w_quick_err   = 1'b0;
    case (bus.ALU_Sel)
      ALU_ADD: begin
        w_quick_out   = {{(WIDTH-1){1'b0}}, w_sum};
        w_quick_carry = w_sum[WIDTH];
      end
      ALU_SUB: begin
        w_quick_out   = {{WIDTH{1'b0}}, w_diff};
        w_quick_carry = (bus.A < bus.B);
      end
      ALU_MUL: w_quick_out = '0;
      ALU_DIV: begin
        w_quick_out = w_b_zero ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : '0;
        w_quick_err = w_b_zero;
      end
      ALU_MOD: begin
        w_quick_out = w_b_zero ? {{WIDTH{1'b0}}, bus.A} : '0;
        w_quick_err = w_b_zero;
      end
      default: w_quick_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_op    <= ALU_ADD;
      r_iter  <= 1'b0;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_op    <= bus.ALU_Sel;
      r_iter  <= w_iter_op;
      r_cnt   <= w_iter_op ? CNT_W'(WIDTH) : '0;
      r_out   <= w_quick_out;
      r_carry <= w_quick_carry;
      r_error <= w_quick_err;
    end else if (r_state == StBusy) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_accept && w_iter_op),
    .i_is_div    (w_is_div),
    .i_cnt       (r_cnt),
    .i_a         (bus.A),
    .i_b         (bus.B),
    .o_product   (w_product),
    .o_quotient  (w_quotient),
    .o_remainder (w_remainder)
  );

  // Iterative results are read straight from the unit's registers once it has settled.
  always_comb begin
    w_result = r_out;
    w_carry  = r_carry;
    if (r_iter) begin
      if (r_op == ALU_MUL) begin
        w_result = w_product;
        w_carry  = |w_product[2*WIDTH-1:WIDTH];
      end else if (r_op == ALU_DIV) begin
        w_result = {{WIDTH{1'b0}}, w_quotient};
      end else begin
        w_result = {{WIDTH{1'b0}}, w_remainder};
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.ALU_Out   = w_result;
  assign bus.CarryOut  = w_carry;
  assign bus.Zero      = w_out_valid && (w_result == '0);
  assign bus.Error     = r_error;

endmodule
